piso_serial_tx: RTL
===================

Name: piso_serial_tx

Overview:
- Parallel-in, serial-out frame transmitter: accepts a WIDTH-bit word on a load/ready handshake and shifts it out on a single line.
- Frame format: start bit, data bits LSB first, stop bit.
- It is the transmitting end of the team's serial bit-stream link. It drives the line that the flip-flop-based serial-in shift-register receiver samples.
- Built from a bit-period counter, a bit index counter, a shift register and a 4-state FSM.

Parameters:
WIDTH, 8, number of data bits per frame (>=1)
DIV, 4, clock cycles each bit is held on tx (>=1; DIV=1 means one bit per clock)

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
din  input  WIDTH  parallel word to transmit; sampled only on an accepted load
load  input  1  request to transmit din
ready  output  1  high when a load will be accepted this cycle
tx  output  1  serial line; idles high
busy  output  1  high while a frame is in progress (START/DATA/STOP)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset values (rst=1 at a rising edge): state=IDLE, tx=1, ready=1, busy=0, done=0, counters=0, shift register=0.
- Reset has priority over every other event. Reset mid-frame aborts the frame: tx=1 and ready=1 from the next cycle, and no done pulse is issued.
- Handshake:
  - A word is accepted at a rising edge where ready=1 and load=1. din is captured into the shift register at that edge.
  - ready=1 only in IDLE. load while busy=1 is ignored; no queueing, and din is not sampled.
- FSM states and transitions:
  - IDLE: tx=1, busy=0. An accepted load goes to START.
  - START: tx=0 for DIV cycles, then goes to DATA with bit index=0.
  - DATA: tx=shift_reg[0], held DIV cycles per bit. At the end of each bit period the register shifts right and the bit index increments. After bit WIDTH-1 completes, goes to STOP.
  - STOP: tx=1 for DIV cycles, then goes to IDLE with done=1 for exactly that first IDLE cycle.
- Latency:
  - tx falls in the cycle immediately after the accept edge. The frame occupies (WIDTH+2)*DIV cycles.
  - done is high in cycle (WIDTH+2)*DIV+1 after acceptance. ready=1 in that same cycle.
- Back-to-back: load=1 during the done cycle is accepted, giving exactly one idle cycle (tx=1) between frames.
- Counters:
  - The bit-period counter is $clog2(DIV)-bit (minimum 1 bit). It counts 0..DIV-1 and wraps to 0 at each bit boundary.
  - The bit index counter is $clog2(WIDTH+1)-bit.
- tx and done are registered outputs: no combinational path from load/din to tx.
- busy = (state != IDLE). ready = (state == IDLE). Exactly one of ready and busy is 1 at all times.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with load=1, din=8'hFF -> tx=1, ready=1, busy=0, done=0. No frame starts after rst is released until load is asserted.
2. Single frame, WIDTH=8, DIV=4, din=8'hA5, load pulsed for 1 cycle:
   - tx sequence, each value held 4 cycles: 0,1,0,1,0,0,1,0,1,1.
   - busy=1 for 40 cycles, then done=1 for exactly 1 cycle with ready=1.
3. Load during busy: mid-frame, assert load with din=8'h00 -> ignored. The frame for 8'hA5 completes unchanged, and no second frame starts.
4. Back-to-back: hold load=1 with din=8'h3C then 8'hC3 -> two complete frames separated by exactly 1 idle cycle of tx=1. Exactly 2 done pulses.
5. Reset mid-frame: assert rst for 1 cycle during data bit 3 -> next cycle tx=1, ready=1, busy=0 with no done pulse. A new load of 8'h81 then transmits a full correct frame.
6. DIV=1, WIDTH=8, din=8'h01 -> tx=0,1,0,0,0,0,0,0,0,1 on consecutive cycles. done is high 11 cycles after acceptance.

Source files
------------

// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out frame transmitter.
// Each frame is a start bit, then WIDTH data bits LSB first, then a stop bit. Every bit is held for DIV clocks.
module piso_serial_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_shift;
    logic             r_tx;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [IW-1:0]    w_idx_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_tx_nxt;
    logic             w_done_nxt;
    logic             w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = din;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    w_idx_nxt   = r_idx + IW'(1);
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // tx is computed from the next state, so the flop holds the bit for the coming cycle.
        unique case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state != S_IDLE);
    assign tx    = r_tx;
    assign done  = r_done;

endmodule
